// File: rtl/i2c_lcd_responder.sv
// I2C target emulating the PCF8574 expander on an LCD backpack: acks ADDR,
// strobes written bytes onto data_out and serves reads from port_in.
module i2c_lcd_responder #(
    parameter logic [6:0] ADDR = 7'h27
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] port_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR_ST, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
    } state_t;

    state_t     state;
    logic       scl_p0, scl_p1, scl_p2;
    logic       sda_p0, sda_p1, sda_p2;
    logic       scl_rise_p3, scl_fall_p3, start_p3, stop_p3, sda_bit_p3;
    logic [2:0] cnt;
    logic       full;
    logic [7:0] shift;

    // Synchronizers and registered bus events; idle bus reads as all ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_p0      <= 1'b1;
            scl_p1      <= 1'b1;
            scl_p2      <= 1'b1;
            sda_p0      <= 1'b1;
            sda_p1      <= 1'b1;
            sda_p2      <= 1'b1;
            scl_rise_p3 <= 1'b0;
            scl_fall_p3 <= 1'b0;
            start_p3    <= 1'b0;
            stop_p3     <= 1'b0;
            sda_bit_p3  <= 1'b1;
        end else begin
            scl_p0      <= scl;
            scl_p1      <= scl_p0;
            scl_p2      <= scl_p1;
            sda_p0      <= sda_in;
            sda_p1      <= sda_p0;
            sda_p2      <= sda_p1;
            scl_rise_p3 <= scl_p1 & ~scl_p2;
            scl_fall_p3 <= ~scl_p1 & scl_p2;
            start_p3    <= scl_p1 & scl_p2 & ~sda_p1 & sda_p2;
            stop_p3     <= scl_p1 & scl_p2 & sda_p1 & ~sda_p2;
            sda_bit_p3  <= sda_p1;
        end
    end

    // Protocol FSM; full marks a completed byte awaiting its ACK slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            full       <= 1'b0;
            shift      <= 8'h00;
            sda_oe     <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (start_p3) begin
                state  <= ADDR_ST;
                cnt    <= 3'd0;
                full   <= 1'b0;
                sda_oe <= 1'b0;
            end else if (stop_p3) begin
                state  <= IDLE;
                full   <= 1'b0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: sda_oe <= 1'b0;
                    ADDR_ST: begin
                        if (scl_rise_p3) begin
                            shift <= {shift[6:0], sda_bit_p3};
                            cnt   <= cnt + 3'd1;
                            if (cnt == 3'd7) full <= 1'b1;
                        end else if (scl_fall_p3 && full) begin
                            full <= 1'b0;
                            if (shift[7:1] == ADDR) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                state  <= ADDR_ACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall_p3) begin
                            cnt <= 3'd0;
                            if (shift[0]) begin
                                shift  <= port_in;
                                sda_oe <= ~port_in[7];
                                state  <= READ;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        if (scl_rise_p3) begin
                            shift <= {shift[6:0], sda_bit_p3};
                            cnt   <= cnt + 3'd1;
                            if (cnt == 3'd7) begin
                                data_out   <= {shift[6:0], sda_bit_p3};
                                data_valid <= 1'b1;
                                full       <= 1'b1;
                            end
                        end else if (scl_fall_p3 && full) begin
                            full   <= 1'b0;
                            sda_oe <= 1'b1;
                            state  <= WRITE_ACK;
                        end
                    end
                    WRITE_ACK: begin
                        if (scl_fall_p3) begin
                            sda_oe <= 1'b0;
                            state  <= WRITE;
                        end
                    end
                    READ: begin
                        if (scl_fall_p3) begin
                            if (cnt == 3'd7) begin
                                cnt    <= 3'd0;
                                sda_oe <= 1'b0;
                                state  <= READ_ACK;
                            end else begin
                                sda_oe <= ~shift[6];
                                shift  <= {shift[6:0], 1'b0};
                                cnt    <= cnt + 3'd1;
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise_p3) begin
                            if (sda_bit_p3) state <= IGNORE;
                            else            full  <= 1'b1;
                        end else if (scl_fall_p3 && full) begin
                            full   <= 1'b0;
                            shift  <= port_in;
                            sda_oe <= ~port_in[7];
                            state  <= READ;
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_lcd_responder.sv
// Bench for i2c_lcd_responder: behavioural I2C controller on a wired-AND SDA line.
module tb_i2c_lcd_responder;

    localparam int H = 10;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] port_in = 8'h00;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] dv_q[$];
    int         oe_cnt = 0;
    bit         oe_watch = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_lcd_responder #(.ADDR(7'h27)) dut (
        .clk(clk), .reset_n(reset_n), .scl(scl), .sda_in(sda_line),
        .sda_oe(sda_oe), .port_in(port_in), .data_out(data_out),
        .data_valid(data_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) dv_q.push_back(data_out);
        if (oe_watch && sda_oe) oe_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bit_cycle(input logic b, output logic r);
        sda_m = b;
        wait_clk(H);
        scl = 1'b1;
        wait_clk(H / 2);
        #1 r = sda_line;
        wait_clk(H / 2);
        scl = 1'b0;
        wait_clk(6);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(H);
        scl = 1'b1;
        wait_clk(H);
        sda_m = 1'b0;
        wait_clk(H);
        scl = 1'b0;
        wait_clk(6);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clk(H);
        scl = 1'b1;
        wait_clk(H);
        sda_m = 1'b1;
        wait_clk(H);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], r);
        bit_cycle(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic ack_it, input logic [7:0] nxt, output logic [7:0] v);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, r);
            v[i] = r;
        end
        port_in = nxt;
        bit_cycle(~ack_it, r);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_clk(3);
        #1;
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got %h want 00", data_out); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        reset_n = 1'b1;
        wait_clk(5);
    endtask

    task automatic test_write();
        logic ack;
        dv_q.delete();
        i2c_start();
        send_byte(8'h4E, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL write_addr_ack got %b want 1", ack); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_after_match got %b want 1", busy); end
        send_byte(8'hA5, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL write_data_ack got %b want 1", ack); end
        i2c_stop();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop got %b want 0", busy); end
        n_checks++; if (dv_q.size() !== 1) begin n_fail++; $display("FAIL write_strobe_count got %0d want 1", dv_q.size()); end
        n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL write_data_out got %h want a5", data_out); end
    endtask

    task automatic test_mismatch();
        logic ack;
        dv_q.delete();
        oe_cnt = 0;
        oe_watch = 1'b1;
        i2c_start();
        send_byte(8'h7E, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mismatch_addr_ack got %b want 0", ack); end
        send_byte(8'hFF, ack);
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mismatch_data_ack got %b want 0", ack); end
        i2c_stop();
        oe_watch = 1'b0;
        n_checks++; if (oe_cnt !== 0) begin n_fail++; $display("FAIL mismatch_sda_oe_cycles got %0d want 0", oe_cnt); end
        n_checks++; if (dv_q.size() !== 0) begin n_fail++; $display("FAIL mismatch_strobes got %0d want 0", dv_q.size()); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mismatch_busy got %b want 0", busy); end
    endtask

    task automatic test_burst();
        logic [7:0] bytes[6] = '{8'h33, 8'h32, 8'h28, 8'h0E, 8'h01, 8'h06};
        logic ack;
        int   n_ack;
        dv_q.delete();
        n_ack = 0;
        i2c_start();
        send_byte(8'h4E, ack);
        for (int i = 0; i < 6; i++) begin
            send_byte(bytes[i], ack);
            if (ack) n_ack++;
        end
        i2c_stop();
        n_checks++; if (n_ack !== 6) begin n_fail++; $display("FAIL burst_acks got %0d want 6", n_ack); end
        n_checks++; if (dv_q.size() !== 6) begin n_fail++; $display("FAIL burst_strobes got %0d want 6", dv_q.size()); end
        for (int i = 0; i < 6 && i < dv_q.size(); i++) begin
            n_checks++; if (dv_q[i] !== bytes[i]) begin n_fail++; $display("FAIL burst_byte%0d got %h want %h", i, dv_q[i], bytes[i]); end
        end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] v;
        port_in = 8'h5C;
        i2c_start();
        send_byte(8'h4F, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL read_addr_ack got %b want 1", ack); end
        read_byte(1'b1, 8'hC3, v);
        n_checks++; if (v !== 8'h5C) begin n_fail++; $display("FAIL read_byte0 got %h want 5c", v); end
        read_byte(1'b0, 8'h00, v);
        n_checks++; if (v !== 8'hC3) begin n_fail++; $display("FAIL read_byte1 got %h want c3", v); end
        oe_cnt = 0;
        oe_watch = 1'b1;
        send_byte(8'hFF, ack);
        oe_watch = 1'b0;
        n_checks++; if (oe_cnt !== 0) begin n_fail++; $display("FAIL read_ignore_sda_oe got %0d cycles want 0", oe_cnt); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL read_ignore_busy got %b want 1", busy); end
        i2c_stop();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_stop_busy got %b want 0", busy); end
    endtask

    task automatic test_repeated_start();
        logic ack, r;
        dv_q.delete();
        i2c_start();
        send_byte(8'h4E, ack);
        bit_cycle(1'b1, r);
        bit_cycle(1'b0, r);
        bit_cycle(1'b1, r);
        bit_cycle(1'b0, r);
        i2c_start();
        send_byte(8'h4E, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rstart_addr_ack got %b want 1", ack); end
        send_byte(8'h12, ack);
        i2c_stop();
        n_checks++; if (dv_q.size() !== 1) begin n_fail++; $display("FAIL rstart_strobes got %0d want 1", dv_q.size()); end
        n_checks++; if (data_out !== 8'h12) begin n_fail++; $display("FAIL rstart_data_out got %h want 12", data_out); end
    endtask

    task automatic test_reset_mid();
        logic ack, r;
        i2c_start();
        send_byte(8'h4E, ack);
        for (int i = 7; i >= 0; i--) bit_cycle(1'(i % 2), r);
        sda_m = 1'b1;
        wait_clk(H);
        scl = 1'b1;
        wait_clk(H / 2);
        #1;
        n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rmid_ack_driven got %b want 1", sda_oe); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rmid_async_sda_oe got %b want 0", sda_oe); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async_busy got %b want 0", busy); end
        wait_clk(4);
        reset_n = 1'b1;
        wait_clk(5);
        dv_q.delete();
        i2c_start();
        send_byte(8'h4E, ack);
        n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rmid_addr_ack got %b want 1", ack); end
        send_byte(8'h77, ack);
        i2c_stop();
        n_checks++; if (dv_q.size() !== 1) begin n_fail++; $display("FAIL rmid_strobes got %0d want 1", dv_q.size()); end
        n_checks++; if (data_out !== 8'h77) begin n_fail++; $display("FAIL rmid_data_out got %h want 77", data_out); end
    endtask

    // Reference: a transaction is claimed only when the 7-bit address equals 0x27
    task automatic test_random();
        logic [6:0] a7;
        logic       rw, ack, match;
        int         nb;
        logic [7:0] v, cur, nxt;
        logic [7:0] exp_q[$];
        for (int t = 0; t < 20; t++) begin
            a7 = ($urandom_range(0, 1) == 1) ? 7'h27 : 7'($urandom_range(0, 127));
            rw = 1'($urandom_range(0, 1));
            nb = $urandom_range(1, 4);
            match = (a7 == 7'h27);
            dv_q.delete();
            exp_q.delete();
            port_in = 8'($urandom);
            i2c_start();
            send_byte({a7, rw}, ack);
            n_checks++; if (ack !== match) begin n_fail++; $display("FAIL rand%0d_addr_ack got %b want %b", t, ack, match); end
            for (int b = 0; b < nb; b++) begin
                if (!rw) begin
                    v = 8'($urandom);
                    exp_q.push_back(v);
                    send_byte(v, ack);
                    n_checks++; if (ack !== match) begin n_fail++; $display("FAIL rand%0d_wr_ack%0d got %b want %b", t, b, ack, match); end
                end else begin
                    cur = port_in;
                    nxt = 8'($urandom);
                    read_byte(b != nb - 1, nxt, v);
                    n_checks++; if (v !== (match ? cur : 8'hFF)) begin n_fail++; $display("FAIL rand%0d_rd%0d got %h want %h", t, b, v, match ? cur : 8'hFF); end
                end
            end
            i2c_stop();
            if (!match || rw) exp_q.delete();
            n_checks++; if (dv_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_strobes got %0d want %0d", t, dv_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < dv_q.size(); i++) begin
                n_checks++; if (dv_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d got %h want %h", t, i, dv_q[i], exp_q[i]); end
            end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_busy got %b want 0", t, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_mismatch();
        test_burst();
        test_read();
        test_repeated_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
